// File: rtl/alu_muldiv.sv
//------------------------------------------------------------------------------
// Module   : alu_muldiv
// Purpose  : Sequential MIPS ALU with iterative multiply/divide and HI/LO.
//            Divider is built only when ALU_DIV_EN is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             divzero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int         c_cw     = $clog2(WIDTH) + 1;
   localparam logic [3:0] c_op_and  = 4'b0000;
   localparam logic [3:0] c_op_or   = 4'b0001;
   localparam logic [3:0] c_op_add  = 4'b0010;
   localparam logic [3:0] c_op_sub  = 4'b0110;
   localparam logic [3:0] c_op_slt  = 4'b0111;
   localparam logic [3:0] c_op_mfhi = 4'b1100;
   localparam logic [3:0] c_op_mflo = 4'b1101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_FIX  = 2'd2
`ifdef ALU_DIV_EN
      , S_DIV = 2'd3
`endif
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [c_cw-1:0]    r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mcand;
   logic               r_neg;

   logic               w_accept;
   logic               w_is_mul;
   logic               w_is_div;
   logic               w_signed;
   logic               w_last;
   logic [WIDTH-1:0]   w_amag;
   logic [WIDTH-1:0]   w_bmag;
   logic [WIDTH-1:0]   w_diff;
   logic               w_ovf;
   logic               w_slt;
   logic [WIDTH-1:0]   w_alu;
   logic [WIDTH:0]     w_madd;
   logic [2*WIDTH-1:0] w_prod;

`ifdef ALU_DIV_EN
   logic               r_isdiv;
   logic               r_dz;
   logic               r_rneg;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_trial;
   logic [2*WIDTH-1:0] w_dstep;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
`endif

   assign ready    = (r_state == S_IDLE);
   assign zero     = (result == '0);
   assign w_accept = start & ready;
   assign w_is_mul = (op[3:1] == 3'b100);
   assign w_is_div = (op[3:1] == 3'b101);
   assign w_signed = op[0];
   assign w_last   = (r_cnt == c_cw'(WIDTH - 1));
   assign w_amag   = (w_signed & a[WIDTH-1]) ? -a : a;
   assign w_bmag   = (w_signed & b[WIDTH-1]) ? -b : b;

   // SLT uses the subtract sign corrected by signed overflow
   assign w_diff = a - b;
   assign w_ovf  = (a[WIDTH-1] ^ b[WIDTH-1]) & (w_diff[WIDTH-1] ^ a[WIDTH-1]);
   assign w_slt  = w_diff[WIDTH-1] ^ w_ovf;

   always_comb begin
      w_alu = '0;
      case (op)
         c_op_and:  w_alu = a & b;
         c_op_or:   w_alu = a | b;
         c_op_add:  w_alu = a + b;
         c_op_sub:  w_alu = w_diff;
         c_op_slt:  w_alu = {{(WIDTH-1){1'b0}}, w_slt};
         c_op_mfhi: w_alu = hi;
         c_op_mflo: w_alu = lo;
         default:   w_alu = '0;
      endcase
   end

   // r_acc holds {partial product, remaining multiplier} during MUL
   assign w_madd = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
   assign w_prod = r_neg ? -r_acc : r_acc;

`ifdef ALU_DIV_EN
   // r_acc holds {partial remainder, dividend/quotient} during DIV
   assign w_shift = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_trial = w_shift - {1'b0, r_mcand};
   assign w_dstep = w_trial[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                   : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
   assign w_quo   = r_neg  ? -r_acc[WIDTH-1:0]       : r_acc[WIDTH-1:0];
   assign w_rem   = r_rneg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept && w_is_mul) w_next = S_MUL;
`ifdef ALU_DIV_EN
            else if (w_accept && w_is_div) w_next = (b == '0) ? S_FIX : S_DIV;
`endif
         end
         S_MUL:   if (w_last) w_next = S_FIX;
`ifdef ALU_DIV_EN
         S_DIV:   if (w_last) w_next = S_FIX;
`endif
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= '0;
         r_acc   <= '0;
         r_mcand <= '0;
         r_neg   <= 1'b0;
         valid   <= 1'b0;
         result  <= '0;
         divzero <= 1'b0;
         hi      <= '0;
         lo      <= '0;
`ifdef ALU_DIV_EN
         r_isdiv <= 1'b0;
         r_dz    <= 1'b0;
         r_rneg  <= 1'b0;
`endif
      end else begin
         valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_is_mul) begin
                     r_acc   <= {{WIDTH{1'b0}}, w_amag};
                     r_mcand <= w_bmag;
                     r_neg   <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                     r_cnt   <= '0;
`ifdef ALU_DIV_EN
                     r_isdiv <= 1'b0;
                  end else if (w_is_div) begin
                     // raw a is kept for the divide-by-zero HI value
                     r_acc   <= {{WIDTH{1'b0}}, (b == '0) ? a : w_amag};
                     r_mcand <= w_bmag;
                     r_neg   <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                     r_rneg  <= w_signed & a[WIDTH-1];
                     r_dz    <= (b == '0);
                     r_isdiv <= 1'b1;
                     r_cnt   <= '0;
`endif
                  end else begin
                     result <= w_alu;
                     valid  <= 1'b1;
`ifndef ALU_DIV_EN
                     if (w_is_div) divzero <= 1'b1;
`endif
                  end
               end
            end
            S_MUL: begin
               r_acc <= {w_madd, r_acc[WIDTH-1:1]};
               r_cnt <= r_cnt + 1'b1;
            end
`ifdef ALU_DIV_EN
            S_DIV: begin
               r_acc <= w_dstep;
               r_cnt <= r_cnt + 1'b1;
            end
`endif
            S_FIX: begin
               valid <= 1'b1;
`ifdef ALU_DIV_EN
               if (r_isdiv) begin
                  divzero <= r_dz;
                  if (r_dz) begin
                     hi     <= r_acc[WIDTH-1:0];
                     lo     <= '1;
                     result <= '1;
                  end else begin
                     hi     <= w_rem;
                     lo     <= w_quo;
                     result <= w_quo;
                  end
               end else
`endif
               begin
                  hi     <= w_prod[2*WIDTH-1:WIDTH];
                  lo     <= w_prod[WIDTH-1:0];
                  result <= w_prod[WIDTH-1:0];
               end
            end
            default: valid <= 1'b0;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_muldiv
// Purpose  : Scoreboard bench for alu_muldiv (WIDTH=32), either ALU_DIV_EN build.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_muldiv;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        ready;
   logic        valid;
   logic [31:0] result;
   logic        zero;
   logic        divzero;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] res;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      logic        chk_dz;
      int          lat;
   } exp_t;

   exp_t        q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic        m_dz = 1'b0;

   alu_muldiv #(.WIDTH(32)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .ready   (ready),
      .valid   (valid),
      .result  (result),
      .zero    (zero),
      .divzero (divzero),
      .hi      (hi),
      .lo      (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // reference model: native arithmetic on 64-bit values
   task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        output exp_t e);
      logic [63:0]        p;
      logic signed [63:0] sx, sy, sq, sr;
      sx = $signed({{32{x[31]}}, x});
      sy = $signed({{32{y[31]}}, y});
      e.lat = 1;
      e.chk_dz = 1'b0;
      e.res = '0;
      case (o)
         4'h0: e.res = x & y;
         4'h1: e.res = x | y;
         4'h2: e.res = x + y;
         4'h6: e.res = x - y;
         4'h7: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         4'h8, 4'h9: begin
            if (o == 4'h8) p = {32'd0, x} * {32'd0, y};
            else           p = sx * sy;
            m_hi = p[63:32];
            m_lo = p[31:0];
            e.res = m_lo;
            e.lat = 34;
         end
         4'hA, 4'hB: begin
            e.chk_dz = 1'b1;
`ifdef ALU_DIV_EN
            if (y == 0) begin
               m_dz = 1'b1; m_lo = '1; m_hi = x; e.lat = 2;
            end else begin
               m_dz = 1'b0; e.lat = 34;
               if (o == 4'hA) begin
                  m_lo = x / y; m_hi = x % y;
               end else begin
                  sq = sx / sy; sr = sx % sy;
                  m_lo = sq[31:0]; m_hi = sr[31:0];
               end
            end
            e.res = m_lo;
`else
            m_dz = 1'b1;
            e.res = '0;
`endif
         end
         4'hC: e.res = m_hi;
         4'hD: e.res = m_lo;
         default: e.res = '0;
      endcase
      e.hi = m_hi;
      e.lo = m_lo;
      e.dz = m_dz;
   endtask

   // drive one request, push its expectation, measure latency to valid
   task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      int   cnt;
      int   guard;
      guard = 0;
      while (!ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!ready) check("ready_wait", 0, 1);
      model(o, x, y, e);
      op = o; a = x; b = y; start = 1'b1;
      q.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      cnt = 1;
      @(negedge clk);
      if (e.lat > 1) check("busy", {63'd0, ready}, 64'd0);
      while (!valid && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      check("latency", cnt, e.lat);
   endtask

   always @(negedge clk) begin
      if (!reset && valid) begin
         if (q.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("result", result, e.res);
            check("zero", zero, (e.res == 0));
            check("hi", hi, e.hi);
            check("lo", lo, e.lo);
            if (e.chk_dz) check("divzero", divzero, e.dz);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] ops [12];
      ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'h3};
      reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_valid", valid, 0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_result", result, 0);
      check("rst_divzero", divzero, 0);

      issue(4'h2, 32'd7, 32'd5);
      issue(4'h7, 32'h8000_0000, 32'h7FFF_FFFF);
      issue(4'h7, 32'h7FFF_FFFF, 32'h8000_0000);
      issue(4'h6, 32'd3, 32'd3);
      issue(4'h0, 32'hF0F0_1234, 32'h0FF0_FFFF);
      issue(4'h1, 32'hF000_0000, 32'h0000_000F);
      issue(4'h3, 32'd1, 32'd2);
      issue(4'h9, 32'hFFFF_FFFD, 32'd6);
      issue(4'hC, 32'd0, 32'd0);
      issue(4'hD, 32'd0, 32'd0);
      issue(4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      issue(4'h9, 32'h8000_0000, 32'h8000_0000);
      issue(4'hB, 32'hFFFF_FFF9, 32'd2);
      issue(4'hA, 32'd100, 32'd0);
      issue(4'hA, 32'd100, 32'd7);
      issue(4'hB, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(4'hB, 32'd7, 32'hFFFF_FFFE);
      issue(4'hB, 32'd9, 32'd3);
      issue(4'hC, 32'd0, 32'd0);
      for (int i = 0; i < 12; i++) begin
         logic [31:0] rb;
         rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         issue(ops[$urandom_range(0, 11)], $urandom, rb);
      end

      // abort a multiply mid-flight; a start while busy must be ignored
      @(negedge clk);
      op = 4'h8; a = 32'hFFFF_FFFF; b = 32'd2; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 start = 1'b1; op = 4'h2; a = 32'd1; b = 32'd1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("abort_ready", ready, 1);
      check("abort_valid", valid, 0);
      check("abort_hi", hi, 0);
      check("abort_lo", lo, 0);
      m_hi = '0; m_lo = '0; m_dz = 1'b0;
      repeat (40) @(negedge clk);
      check("abort_queue", q.size(), 0);
      issue(4'hC, 32'd0, 32'd0);
      issue(4'hD, 32'd0, 32'd0);
      issue(4'h9, 32'd12345, 32'hFFFF_FF00);
      issue(4'h2, 32'hFFFF_FFFF, 32'd1);
      repeat (3) @(negedge clk);
      check("final_queue", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
